iq_mag_avg_multi: RTL
=====================

// Module: iq_mag_avg_multi
// PURPOSE
// Multi-channel successor of the IQ RSSI averager for the xpu receive path. For each of
// NUM_CH antenna IQ streams: |I|,|Q| (saturating), per-sample magnitude estimate (runtime
// selectable mode), moving average over a runtime-selectable 2^L window. A settled flag
// marks a full window; CCA/AGC logic downstream gates decisions on it.
// PARAMETERS
// IQ_DATA_WIDTH     16  signed width of each I and Q sample and of each rssi output
// NUM_CH            2   number of independent IQ channels sharing one valid strobe
// MAX_LOG2_AVG_LEN  6   max log2 window; delay-line depth per channel = 2^MAX_LOG2_AVG_LEN
// PORTS
// clk               in   1                  clock
// rstn              in   1                  asynchronous active-low reset
// iq_in             in   NUM_CH*2*W         ch k at [2kW +: 2W], packed {q,i}, signed (W=IQ_DATA_WIDTH)
// iq_in_valid       in   1                  one sample per channel this cycle
// mag_mode          in   1                  0: (|I|+|Q|)>>1 ; 1: max(|I|,|Q|) + (min>>2)
// cfg_log2_avg_len  in   3                  window L; values > MAX_LOG2_AVG_LEN clamp to MAX
// avg_clear         in   1                  synchronous flush of all windows
// rssi              out  NUM_CH*W           ch k at [kW +: W], unsigned value in signed W-bit field
// rssi_valid        out  1                  rssi updated this cycle
// rssi_settled      out  1                  >= 2^L samples accumulated since last flush
// BEHAVIOUR
// - Reset: rssi=0, rssi_valid=0, rssi_settled=0; sums, fill counter, pointers, pipe valids=0.
//   Delay-line RAM not reset (never read before written, see warm-up).
// - Pipeline, 3 cycles, valid-qualified; no backpressure, a sample accepted every valid cycle:
//   S1 abs: |x|; -2^(W-1) saturates to 2^(W-1)-1.
//   S2 mag: mode 0 (a+b)>>1; mode 1 max+(min>>2) computed W+1 bits, saturated to 2^(W-1)-1.
//       mag_mode sampled at S2 per sample; change causes no flush.
//   S3 acc: sum += mag - old; sum width W+MAX_LOG2_AVG_LEN, unsigned, never wraps.
// - iq_in_valid at cycle t -> rssi_valid high at t+3, rssi = sum_new >> L (truncate).
// - Delay line: circular, one write per S3 valid, wr_ptr wraps at 2^MAX; old =
//   mem[(wr_ptr - 2^L) mod 2^MAX] when fill_cnt >= 2^L, else 0 (warm-up).
// - fill_cnt saturates at 2^L; rssi_settled = (fill_cnt == 2^L), updated with rssi_valid.
//   During warm-up rssi = partial sum >> L (underestimate, by design).
// - Flush (avg_clear=1, or registered effective L differs from clamped cfg_log2_avg_len):
//   next cycle sums=0, fill_cnt=0, wr_ptr=0, rssi_settled=0, all S1-S3 valids=0,
//   rssi_valid=0; rssi holds last value. Samples in flight or arriving that cycle dropped.
//   New L effective from the flush; first accepted sample is the one after flush cycle.
// - Flush and iq_in_valid same cycle: flush wins, sample discarded.
// - rstn asserted mid-stream: immediate return to reset values, no partial outputs.
// - All channels share pointers, fill_cnt and valids; only data paths replicated.
// TESTING
// 1 Reset, L=5, mode0, ch0 I=Q=1000 every cycle: rssi_valid 3 cycles after first valid;
//   ch0 rssi ramps 31,62..; settled and rssi=1000 on 32nd output.
// 2 I=-32768,Q=-32768, mode0 -> abs saturates, settled rssi=32767; mode1 -> 32767 (clamped).
// 3 L=3, mode1, I=400,Q=-100: mag=425; settled after 8 outputs, rssi=425;
//   ch1 I=Q=0 concurrently -> ch1 rssi stays 0 (channel isolation).
// 4 Settled at L=4, then cfg_log2_avg_len=2: one flush, settled low, rssi_valid low
//   for in-flight samples, settled again after 4 new outputs with correct average.
// 5 avg_clear pulsed same cycle as a valid with sparse valids (1 in 3): that sample never
//   contributes; wr_ptr wrap at L=MAX after 200 samples -> rssi matches reference model.
// 6 rstn low mid-window at L=6: outputs zero immediately; after release, warm-up restarts.

Source files
------------

// File: rtl/iq_mag_avg_multi.sv
// Multi-channel IQ magnitude estimator with a runtime-selectable 2^L moving average.
// Channels share the pipeline valids, delay-line pointers and fill counter.
module iq_mag_avg_multi #(
    parameter int IQ_DATA_WIDTH    = 16,
    parameter int NUM_CH           = 2,
    parameter int MAX_LOG2_AVG_LEN = 6
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] iq_in,
    input  logic                              iq_in_valid,
    input  logic                              mag_mode,
    input  logic [2:0]                        cfg_log2_avg_len,
    input  logic                              avg_clear,
    output logic [NUM_CH*IQ_DATA_WIDTH-1:0]   rssi,
    output logic                              rssi_valid,
    output logic                              rssi_settled
);
    localparam int W     = IQ_DATA_WIDTH;
    localparam int ML    = MAX_LOG2_AVG_LEN;
    localparam int DEPTH = 1 << ML;
    localparam int SW    = W + ML;
    localparam logic [2:0]  ML3      = 3'(ML);
    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [ML:0]  FILL_ONE = 1;
    localparam logic [ML-1:0] PTR_ONE = 1;

    logic [2:0]    eff_l;
    logic [2:0]    cfg_l;
    logic          flush;
    logic          v1;
    logic          v2;
    logic [ML-1:0] wr_ptr;
    logic [ML-1:0] rd_ptr;
    logic [ML:0]   fill_cnt;
    logic [ML:0]   fill_next;
    logic [ML:0]   win;
    logic          full;

    function automatic logic [W-1:0] abs_sat(input logic [W-1:0] x);
        if (x == NEG_MIN)
            return POS_MAX;
        else if (x[W-1])
            return -x;
        else
            return x;
    endfunction

    always_comb begin
        cfg_l     = (cfg_log2_avg_len > ML3) ? ML3 : cfg_log2_avg_len;
        flush     = avg_clear | (eff_l != cfg_l);
        win       = FILL_ONE << eff_l;
        full      = (fill_cnt == win);
        fill_next = full ? fill_cnt : fill_cnt + FILL_ONE;
        // Oldest sample in the window; wraps naturally when L equals the max.
        rd_ptr    = wr_ptr - win[ML-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eff_l        <= ML3;
            v1           <= 1'b0;
            v2           <= 1'b0;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            rssi_valid   <= 1'b0;
            rssi_settled <= 1'b0;
        end else begin
            v1 <= iq_in_valid & ~flush;
            v2 <= v1 & ~flush;
            if (flush) begin
                eff_l        <= cfg_l;
                wr_ptr       <= '0;
                fill_cnt     <= '0;
                rssi_valid   <= 1'b0;
                rssi_settled <= 1'b0;
            end else begin
                rssi_valid <= v2;
                if (v2) begin
                    wr_ptr       <= wr_ptr + PTR_ONE;
                    fill_cnt     <= fill_next;
                    rssi_settled <= (fill_next == win);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [W-1:0]  i_s;
        logic [W-1:0]  q_s;
        logic [W-1:0]  abs_i;
        logic [W-1:0]  abs_q;
        logic [W-1:0]  mag;
        logic [W-1:0]  mag_d;
        logic [W-1:0]  old;
        logic [W:0]    a_w;
        logic [W:0]    b_w;
        logic [W:0]    mx;
        logic [W:0]    mn;
        logic [W:0]    mag_w;
        logic [SW-1:0] sum;
        logic [SW-1:0] sum_new;
        logic [W-1:0]  rssi_r;
        logic [W-1:0]  mem [DEPTH];

        assign i_s = iq_in[2*k*W +: W];
        assign q_s = iq_in[2*k*W+W +: W];

        always_comb begin
            a_w   = {1'b0, abs_i};
            b_w   = {1'b0, abs_q};
            mx    = (a_w >= b_w) ? a_w : b_w;
            mn    = (a_w >= b_w) ? b_w : a_w;
            mag_w = mag_mode ? mx + (mn >> 2) : (a_w + b_w) >> 1;
            mag_d = (mag_w > {1'b0, POS_MAX}) ? POS_MAX : mag_w[W-1:0];
            old     = full ? mem[rd_ptr] : '0;
            sum_new = sum + {{ML{1'b0}}, mag} - {{ML{1'b0}}, old};
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                abs_i  <= '0;
                abs_q  <= '0;
                mag    <= '0;
                sum    <= '0;
                rssi_r <= '0;
            end else begin
                if (iq_in_valid) begin
                    abs_i <= abs_sat(i_s);
                    abs_q <= abs_sat(q_s);
                end
                if (v1)
                    mag <= mag_d;
                if (flush)
                    sum <= '0;
                else if (v2) begin
                    sum    <= sum_new;
                    rssi_r <= W'(sum_new >> eff_l);
                end
            end
        end

        // Delay line is write-before-read safe, so it carries no reset.
        always_ff @(posedge clk) begin
            if (v2 && !flush)
                mem[wr_ptr] <= mag;
        end

        assign rssi[k*W +: W] = rssi_r;
    end
endmodule
